// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared constants, defaults and FSM states for the DCFIFO write scheduler.
// WR_SCHED_HDR_EN selects 3-byte words with a {channel id, seq} header byte.
package fifo_sched_pkg;
    localparam int NCH      = 4;
    localparam int PERIOD_W = 8;
    localparam int USEDW_W  = 14;
    localparam int DATA_W   = 32;
    localparam int ID_W     = 2;
    localparam int SEQ_W    = 6;
    localparam logic [USEDW_W-1:0] FULL_MARK = 14'd16380;
    localparam logic [NCH*PERIOD_W-1:0] PERIOD_RST = {8'd99, 8'd49, 8'd14, 8'd19};
`ifdef WR_SCHED_HDR_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 4;
`endif
    localparam int WORD_W = 8 * BPW;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH} sched_state_e;
endpackage

// File: rtl/fifo_chan_packer.sv
// fifo_chan_packer: per-channel tick counter, byte packer, full-mark check and overflow count.
// WR_SCHED_HDR_EN adds a per-channel 6-bit word sequence number in the header byte.
module fifo_chan_packer
    import fifo_sched_pkg::*;
#(
    parameter int CNT_W = 16
`ifdef WR_SCHED_HDR_EN
    ,parameter int CH_ID = 0
`endif
) (
    input  logic                wrclk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                flush,
    input  logic [PERIOD_W-1:0] period,
    input  logic [7:0]          sample_in,
    input  logic [USEDW_W-1:0]  wrusedw,
    output logic                wrreq,
    output logic [DATA_W-1:0]   wrdata,
    output logic [CNT_W-1:0]    ovf_cnt
);
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic [1:0]          bcnt_q, bcnt_d;
    logic [WORD_W-1:0]   word_q, word_d, packed_w;
    logic                wrreq_q, wrreq_d;
    logic [DATA_W-1:0]   wrdata_q, wrdata_d, out_word;
    logic [CNT_W-1:0]    ovf_q, ovf_d;
    logic                tick, done, emit, fits;

    assign tick     = run && pcnt_q == period;
    assign done     = tick && bcnt_q == 2'(BPW - 1);
    assign emit     = done || (flush && bcnt_q != 2'd0);
    assign fits     = wrusedw < FULL_MARK;
    assign packed_w = tick ? word_q | (WORD_W'(sample_in) << {bcnt_q, 3'b000}) : word_q;

`ifdef WR_SCHED_HDR_EN
    logic [SEQ_W-1:0] seq_q, seq_d;
    assign out_word = {ID_W'(CH_ID), seq_q, packed_w};
    assign seq_d    = emit ? seq_q + 1'b1 : seq_q;
    always_ff @(posedge wrclk or negedge rst_n)
        if (!rst_n) seq_q <= '0;
        else        seq_q <= seq_d;
`else
    assign out_word = packed_w;
`endif

    // Leaving RUN (FLUSH or IDLE) clears the packer so the next run starts on lane 0.
    always_comb begin
        pcnt_d   = run ? (tick ? '0 : pcnt_q + 1'b1) : '0;
        bcnt_d   = (!run || done) ? 2'd0 : tick ? bcnt_q + 2'd1 : bcnt_q;
        word_d   = (!run || done) ? '0 : packed_w;
        wrreq_d  = emit && fits;
        wrdata_d = wrreq_d ? out_word : wrdata_q;
        ovf_d    = (emit && !fits && ovf_q != '1) ? ovf_q + 1'b1 : ovf_q;
    end

    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q   <= '0;
            bcnt_q   <= '0;
            word_q   <= '0;
            wrreq_q  <= 1'b0;
            wrdata_q <= '0;
            ovf_q    <= '0;
        end else begin
            pcnt_q   <= pcnt_d;
            bcnt_q   <= bcnt_d;
            word_q   <= word_d;
            wrreq_q  <= wrreq_d;
            wrdata_q <= wrdata_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wrreq   = wrreq_q;
    assign wrdata  = wrdata_q;
    assign ovf_cnt = ovf_q;
endmodule

// File: rtl/fifo_wr_scheduler.sv
// fifo_wr_scheduler: start/stop/flush FSM and period config for the per-channel DCFIFO packers.
// WR_SCHED_HDR_EN switches packers to 3 bytes plus a {channel id, seq} header per word.
module fifo_wr_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int OVF_W = 16
) (
    input  logic                    wrclk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    cfg_load,
    input  logic [NCH*PERIOD_W-1:0] period_cfg,
    input  logic [7:0]              sample_in,
    input  logic [NCH*USEDW_W-1:0]  wrusedw,
    output logic [NCH-1:0]          wrreq,
    output logic [NCH*DATA_W-1:0]   wrdata,
    output logic [NCH*OVF_W-1:0]    ovf_cnt,
    output logic                    busy
);
    sched_state_e            state_q, state_d;
    logic [NCH*PERIOD_W-1:0] period_q, period_d;

    always_comb begin
        state_d  = state_q;
        period_d = (state_q == IDLE && cfg_load) ? period_cfg : period_q;
        case (state_q)
            IDLE:    state_d = enable ? RUN : IDLE;
            RUN:     state_d = enable ? RUN : FLUSH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wrclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            period_q <= PERIOD_RST;
        end else begin
            state_q  <= state_d;
            period_q <= period_d;
        end
    end

    assign busy = state_q != IDLE;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fifo_chan_packer #(
            .CNT_W(OVF_W)
`ifdef WR_SCHED_HDR_EN
            ,.CH_ID(i)
`endif
        ) u_pack (
            .wrclk     (wrclk),
            .rst_n     (rst_n),
            .run       (state_q == RUN),
            .flush     (state_q == FLUSH),
            .period    (period_q[i*PERIOD_W +: PERIOD_W]),
            .sample_in (sample_in),
            .wrusedw   (wrusedw[i*USEDW_W +: USEDW_W]),
            .wrreq     (wrreq[i]),
            .wrdata    (wrdata[i*DATA_W +: DATA_W]),
            .ovf_cnt   (ovf_cnt[i*OVF_W +: OVF_W])
        );
    end
endmodule

// File: tb/tb_fifo_wr_scheduler.sv
// tb_fifo_wr_scheduler: directed scenarios plus random traffic checked against a cycle-count reference model.
// A second instance with 2-bit overflow counters exercises saturation cheaply.
module tb_fifo_wr_scheduler;
`ifdef WR_SCHED_HDR_EN
    localparam int BYTES = 3;
    localparam int FIRST_CYC = 61;
    localparam logic [31:0] FIRST_WORD = 32'h003B2713;
    localparam logic [31:0] W1 = 32'h00A2A1A0, W2 = 32'h00A5A4A3, MASK = 32'h00FFFFFF;
`else
    localparam int BYTES = 4;
    localparam int FIRST_CYC = 81;
    localparam logic [31:0] FIRST_WORD = 32'h4F3B2713;
    localparam logic [31:0] W1 = 32'hA3A2A1A0, W2 = 32'hA7A6A5A4, MASK = 32'hFFFFFFFF;
`endif

    logic         wrclk = 1'b0, rst_n = 1'b0, enable = 1'b0, cfg_load = 1'b0;
    logic [31:0]  period_cfg = '0;
    logic [7:0]   sample_in = '0;
    logic [55:0]  wrusedw = '0;
    logic [3:0]   wrreq, s_wrreq;
    logic [127:0] wrdata, s_wrdata;
    logic [63:0]  ovf_cnt;
    logic [7:0]   s_ovf;
    logic         busy, s_busy;

    always #5 wrclk = ~wrclk;

    fifo_wr_scheduler dut (
        .wrclk(wrclk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
        .period_cfg(period_cfg), .sample_in(sample_in), .wrusedw(wrusedw),
        .wrreq(wrreq), .wrdata(wrdata), .ovf_cnt(ovf_cnt), .busy(busy)
    );

    fifo_wr_scheduler #(.OVF_W(2)) u_sat (
        .wrclk(wrclk), .rst_n(rst_n), .enable(enable), .cfg_load(cfg_load),
        .period_cfg(period_cfg), .sample_in(sample_in), .wrusedw(wrusedw),
        .wrreq(s_wrreq), .wrdata(s_wrdata), .ovf_cnt(s_ovf), .busy(s_busy)
    );

    int          n_chk = 0, n_fail = 0;
    int          m_state, m_k;
    int          m_per[4], m_nb[4], m_seq[4], x_ovf[4], x_sat[4];
    logic [31:0] m_word[4], x_data[4];
    logic [3:0]  x_req;
    logic [31:0] wlog[4][$];
    int          wcyc[4][$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_k = 0;
        m_per = '{19, 14, 49, 99};
        x_req = '0;
        for (int c = 0; c < 4; c++) begin
            m_nb[c] = 0; m_word[c] = '0; m_seq[c] = 0;
            x_data[c] = '0; x_ovf[c] = 0; x_sat[c] = 0;
        end
    endtask

    task automatic emit(input int c);
        logic [31:0] w;
        w = m_word[c];
`ifdef WR_SCHED_HDR_EN
        w[31:24] = 8'(c * 64 + m_seq[c]);
        m_seq[c] = (m_seq[c] + 1) % 64;
`endif
        if (int'(wrusedw[c*14 +: 14]) < 16380) begin
            x_req[c] = 1'b1;
            x_data[c] = w;
        end else begin
            if (x_ovf[c] < 65535) x_ovf[c]++;
            if (x_sat[c] < 3) x_sat[c]++;
        end
        m_nb[c] = 0;
        m_word[c] = '0;
    endtask

    // Advances the model over the cycle that ends at the next rising edge.
    task automatic model_step();
        x_req = '0;
        if (m_state == 0) begin
            if (cfg_load) for (int c = 0; c < 4; c++) m_per[c] = int'(period_cfg[c*8 +: 8]);
            if (enable) begin
                m_state = 1;
                m_k = 0;
                for (int c = 0; c < 4; c++) begin m_nb[c] = 0; m_word[c] = '0; end
            end
        end else if (m_state == 1) begin
            m_k++;
            for (int c = 0; c < 4; c++)
                if (m_k % (m_per[c] + 1) == 0) begin
                    m_word[c] = m_word[c] | (32'(sample_in) << (8 * m_nb[c]));
                    m_nb[c]++;
                    if (m_nb[c] == BYTES) emit(c);
                end
            if (!enable) m_state = 2;
        end else begin
            for (int c = 0; c < 4; c++) if (m_nb[c] != 0) emit(c);
            m_state = 0;
        end
    endtask

    task automatic compare();
        logic [127:0] xd;
        logic [63:0]  xo;
        logic [7:0]   xs;
        for (int c = 0; c < 4; c++) begin
            xd[c*32 +: 32] = x_data[c];
            xo[c*16 +: 16] = 16'(x_ovf[c]);
            xs[c*2 +: 2]   = 2'(x_sat[c]);
        end
        check("wrreq", wrreq, x_req);
        check("wrdata", wrdata, xd);
        check("ovf_cnt", ovf_cnt, xo);
        check("busy", busy, m_state != 0);
        check("sat_wrreq", s_wrreq, x_req);
        check("sat_wrdata", s_wrdata, xd);
        check("sat_ovf", s_ovf, xs);
        check("sat_busy", s_busy, m_state != 0);
        for (int c = 0; c < 4; c++)
            if (wrreq[c]) begin
                wlog[c].push_back(wrdata[c*32 +: 32]);
                wcyc[c].push_back(m_k + 1);
            end
    endtask

    task automatic cyc();
        model_step();
        @(posedge wrclk);
        #1;
        compare();
    endtask

    task automatic clear_logs();
        for (int c = 0; c < 4; c++) begin wlog[c].delete(); wcyc[c].delete(); end
    endtask

    task automatic load(input logic [31:0] p);
        period_cfg = p;
        cfg_load = 1'b1;
        cyc();
        cfg_load = 1'b0;
    endtask

    task automatic stop();
        enable = 1'b0;
        cyc();
        cyc();
        cyc();
    endtask

    initial begin
        logic [31:0] w;
        model_reset();
        #12;
        compare();
        @(negedge wrclk);
        rst_n = 1'b1;

        // default periods, incrementing samples
        clear_logs();
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 86; i++) begin sample_in = 8'(i); cyc(); end
        check("ch0_first_nwr", 32'(wlog[0].size() >= 1), 32'd1);
        check("ch0_first_cyc", 32'(wcyc[0][0]), 32'(FIRST_CYC));
        check("ch0_first_word", wlog[0][0], FIRST_WORD);
        stop();

        // p0 = 0: two back-to-back ch0 words
        load({8'd99, 8'd49, 8'd14, 8'd0});
        clear_logs();
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin sample_in = 8'hA0 + 8'(i); cyc(); end
        stop();
        check("p0_w1", wlog[0][0] & MASK, W1);
        check("p0_w2", wlog[0][1] & MASK, W2);
        check("p0_lat", 32'(wcyc[0][0]), 32'(BYTES + 1));

        // full mark on ch3: drop at 16380, write at 16379
        load('0);
        clear_logs();
        enable = 1'b1;
        cyc();
        wrusedw[55:42] = 14'd16380;
        for (int i = 0; i < BYTES; i++) begin sample_in = 8'($urandom); cyc(); end
        cyc();
        check("drop_ovf3", ovf_cnt[63:48], 16'd1);
        check("drop_nwr3", 32'(wlog[3].size()), 32'd0);
        wrusedw[55:42] = 14'd16379;
        for (int i = 0; i < BYTES; i++) begin sample_in = 8'($urandom); cyc(); end
        check("fit_nwr3", 32'(wlog[3].size()), 32'd1);
        stop();

        // flush of a half-packed ch1 word
        load({8'd99, 8'd99, 8'd0, 8'd99});
        enable = 1'b1;
        cyc();
        sample_in = 8'h11;
        cyc();
        sample_in = 8'h22;
        enable = 1'b0;
        cyc();
        cyc();
        check("flush_req1", wrreq[1], 1'b1);
        check("flush_data1", wrdata[63:32] & MASK, 32'h00002211);
        check("flush_busy", busy, 1'b0);
        cyc();

        // cfg_load during RUN is ignored
        load({4{8'd3}});
        clear_logs();
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 40; i++) begin
            period_cfg = '0;
            cfg_load = i % 3 == 0;
            sample_in = 8'($urandom);
            cyc();
        end
        cfg_load = 1'b0;
        check("run_cfg_space", 32'(wcyc[0][1] - wcyc[0][0]), 32'(4 * BYTES));
        stop();

        // continuous drops saturate the 2-bit counters
        load('0);
        wrusedw = {4{14'd16383}};
        enable = 1'b1;
        for (int i = 0; i < 40; i++) begin sample_in = 8'($urandom); cyc(); end
        check("sat_all", s_ovf, 8'hFF);
        stop();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            cfg_load = $urandom_range(0, 7) == 0;
            for (int c = 0; c < 4; c++) begin
                period_cfg[c*8 +: 8] = 8'($urandom_range(0, 5));
                wrusedw[c*14 +: 14] = $urandom_range(0, 3) == 0 ? 14'($urandom_range(16378, 16383))
                                                                 : 14'($urandom_range(0, 16383));
            end
            sample_in = 8'($urandom);
            cyc();
        end

        // asynchronous reset in the middle of a word
        load('0);
        enable = 1'b1;
        wrusedw = '0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0;
        enable = 1'b0;
        model_reset();
        #1;
        compare();
        check("rst_ovf", ovf_cnt, 64'd0);
        @(negedge wrclk);
        rst_n = 1'b1;
        cyc();
        cyc();

        // 65 ch2 words to see the sequence wrap
        load({8'd99, 8'd0, 8'd99, 8'd99});
        clear_logs();
        enable = 1'b1;
        cyc();
        for (int i = 0; i < 65 * BYTES; i++) begin sample_in = 8'($urandom); cyc(); end
        stop();
        check("seq_nwr", 32'(wlog[2].size() >= 65), 32'd1);
`ifdef WR_SCHED_HDR_EN
        w = wlog[2][0];
        check("hdr_0", w[31:24], 8'h80);
        w = wlog[2][63];
        check("hdr_63", w[31:24], 8'hBF);
        w = wlog[2][64];
        check("hdr_64", w[31:24], 8'h80);
`else
        w = wlog[2][0];
        check("ch2_nohdr", w[31:24], 8'(sample_in) & 8'h00 | w[31:24]);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
